aipp_core_mc: RTL and testbench

Multi-channel successor to the single-rail AIPP control engine. It accepts time-multiplexed, channel-tagged voltage-health telemetry from the header parser. It runs an independent protection FSM per power channel, with configurable thresholds, dwell-qualified recovery and a linear rate ramp-up, and drives one rate-limiter word per channel. It sits between the telemetry parser and the egress rate limiters, and raises one aggregated, sticky, maskable interrupt.

---
 rtl/aipp_core_mc.sv | 160 ++++++++++++++++
 tb/tb_aipp_core_mc.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aipp_core_mc.sv
// Multi-channel AIPP protection engine: one protection FSM per power channel fed by
// time-multiplexed, channel-tagged health telemetry, driving a per-channel rate-limit word
// and a single aggregated, sticky, maskable alert interrupt.
module aipp_core_mc #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CH_W = 2,
  parameter int unsigned HW   = 4,
  parameter int unsigned RW   = 16,
  parameter int unsigned DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tel_vld,
  input  logic [CH_W-1:0]      tel_ch,
  input  logic [HW-1:0]        tel_health,
  input  logic [HW-1:0]        cfg_thr_throttle,
  input  logic [HW-1:0]        cfg_thr_critical,
  input  logic [HW-1:0]        cfg_thr_recover,
  input  logic [HW-1:0]        cfg_thr_release,
  input  logic [DW-1:0]        cfg_dwell,
  input  logic [RW-1:0]        cfg_throttle_rate,
  input  logic [RW-1:0]        cfg_ramp_step,
  input  logic [N_CH-1:0]      intr_mask,
  input  logic [N_CH-1:0]      intr_clr,
  output logic [N_CH*RW-1:0]   rate_limit,
  output logic [N_CH*3-1:0]    ch_state,
  output logic [N_CH-1:0]      alert_status,
  output logic                 intr_alert
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StNominal  = 3'd1,
    StThrottle = 3'd2,
    StAlert    = 3'd3,
    StRecover  = 3'd4
  } state_e;

  // Threshold decisions are shared by all channels; only the addressed channel acts on them.
  logic          lt_crit, lt_thr, gt_rec, gt_rel;
  logic [DW-1:0] dwell_tgt;
  logic [RW-1:0] ramp_step;

  assign lt_crit   = tel_health < cfg_thr_critical;
  assign lt_thr    = tel_health < cfg_thr_throttle;
  assign gt_rec    = tel_health > cfg_thr_recover;
  assign gt_rel    = tel_health > cfg_thr_release;
  // Zero dwell / zero step would stall the FSM, so both are promoted to 1.
  assign dwell_tgt = (cfg_dwell == '0) ? DW'(1) : cfg_dwell;
  assign ramp_step = (cfg_ramp_step == '0) ? RW'(1) : cfg_ramp_step;

  logic [N_CH-1:0] alert_set;
  logic [N_CH-1:0] alert_status_q;
  logic            intr_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_e        state_q;
    logic [RW-1:0] rate_q;
    logic [DW-1:0] dwell_q;
    logic          hit;
    logic [DW-1:0] dwell_inc;
    logic [RW:0]   ramp_sum;
    logic [RW-1:0] ramp_sat;

    // Indices >= N_CH match no channel, so such samples are dropped.
    assign hit       = tel_vld && (tel_ch == CH_W'(i));
    assign dwell_inc = (&dwell_q) ? dwell_q : dwell_q + DW'(1);
    assign ramp_sum  = {1'b0, rate_q} + {1'b0, ramp_step};
    assign ramp_sat  = ramp_sum[RW] ? '1 : ramp_sum[RW-1:0];
    assign alert_set[i] = hit && lt_crit &&
                          (state_q == StNominal || state_q == StThrottle ||
                           state_q == StRecover);

    // Per-channel protection FSM with registered rate and dwell counter.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= StIdle;
        rate_q  <= '1;
        dwell_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (hit) state_q <= StNominal;
          end
          StNominal: begin
            if (hit && lt_crit) begin
              state_q <= StAlert;
              rate_q  <= '0;
            end else if (hit && lt_thr) begin
              state_q <= StThrottle;
              rate_q  <= cfg_throttle_rate;
              dwell_q <= '0;
            end
          end
          StThrottle: begin
            if (hit) begin
              if (lt_crit) begin
                state_q <= StAlert;
                rate_q  <= '0;
              end else if (gt_rec) begin
                if (dwell_inc >= dwell_tgt) begin
                  state_q <= StRecover;
                  dwell_q <= '0;
                end else begin
                  dwell_q <= dwell_inc;
                end
              end else begin
                dwell_q <= '0;
              end
            end
          end
          StRecover: begin
            // A sample-driven exit replaces this cycle's ramp step.
            if (hit && lt_crit) begin
              state_q <= StAlert;
              rate_q  <= '0;
            end else if (hit && lt_thr) begin
              state_q <= StThrottle;
              rate_q  <= cfg_throttle_rate;
              dwell_q <= '0;
            end else begin
              rate_q <= ramp_sat;
              if (&ramp_sat) state_q <= StNominal;
            end
          end
          StAlert: begin
            if (hit && gt_rel) begin
              state_q <= StThrottle;
              rate_q  <= cfg_throttle_rate;
              dwell_q <= '0;
            end
          end
          default: begin
            state_q <= StIdle;
            rate_q  <= '1;
            dwell_q <= '0;
          end
        endcase
      end
    end

    assign ch_state[i*3 +: 3]    = state_q;
    assign rate_limit[i*RW +: RW] = rate_q;
  end

  // Sticky alert flags (set beats clear) and the registered, masked interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alert_status_q <= '0;
      intr_q         <= 1'b0;
    end else begin
      alert_status_q <= (alert_status_q & ~intr_clr) | alert_set;
      intr_q         <= |(alert_status_q & ~intr_mask);
    end
  end

  assign alert_status = alert_status_q;
  assign intr_alert   = intr_q;

endmodule

// File: tb/tb_aipp_core_mc.sv
// Self-checking bench for aipp_core_mc: a behavioural reference model pushes expected
// outputs into a scoreboard each cycle; scenario tasks pop and compare after the edge.
module tb_aipp_core_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tel_vld;
  logic [1:0]  tel_ch;
  logic [3:0]  tel_health;
  logic [3:0]  cfg_thr_throttle, cfg_thr_critical, cfg_thr_recover, cfg_thr_release;
  logic [7:0]  cfg_dwell;
  logic [15:0] cfg_throttle_rate, cfg_ramp_step;
  logic [3:0]  intr_mask, intr_clr;

  logic [63:0] rate_limit;
  logic [11:0] ch_state;
  logic [3:0]  alert_status;
  logic        intr_alert;

  logic [47:0] rate3;
  logic [8:0]  st3;
  logic [2:0]  al3;
  logic        intr3;

  always #5 clk = ~clk;

  aipp_core_mc #(.N_CH(4), .CH_W(2), .HW(4), .RW(16), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .tel_vld(tel_vld), .tel_ch(tel_ch), .tel_health(tel_health),
    .cfg_thr_throttle(cfg_thr_throttle), .cfg_thr_critical(cfg_thr_critical),
    .cfg_thr_recover(cfg_thr_recover), .cfg_thr_release(cfg_thr_release),
    .cfg_dwell(cfg_dwell), .cfg_throttle_rate(cfg_throttle_rate),
    .cfg_ramp_step(cfg_ramp_step), .intr_mask(intr_mask), .intr_clr(intr_clr),
    .rate_limit(rate_limit), .ch_state(ch_state), .alert_status(alert_status),
    .intr_alert(intr_alert)
  );

  // Three-channel instance: tel_ch=3 must be dropped.
  aipp_core_mc #(.N_CH(3), .CH_W(2), .HW(4), .RW(16), .DW(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .tel_vld(tel_vld), .tel_ch(tel_ch), .tel_health(tel_health),
    .cfg_thr_throttle(cfg_thr_throttle), .cfg_thr_critical(cfg_thr_critical),
    .cfg_thr_recover(cfg_thr_recover), .cfg_thr_release(cfg_thr_release),
    .cfg_dwell(cfg_dwell), .cfg_throttle_rate(cfg_throttle_rate),
    .cfg_ramp_step(cfg_ramp_step), .intr_mask(intr_mask[2:0]), .intr_clr(intr_clr[2:0]),
    .rate_limit(rate3), .ch_state(st3), .alert_status(al3), .intr_alert(intr3)
  );

  typedef struct {
    logic [11:0] st;
    logic [63:0] rate;
    logic [3:0]  alert;
    logic        intr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int          m_st[4];
  logic [15:0] m_rate[4];
  logic [7:0]  m_dw[4];
  logic [3:0]  m_alert;
  logic        m_intr;

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_st[c] = 0; m_rate[c] = 16'hFFFF; m_dw[c] = 8'd0;
    end
    m_alert = 4'd0;
    m_intr  = 1'b0;
  endtask

  // Reference model: advance one clock using the inputs currently applied.
  task automatic model_step();
    logic [3:0] set;
    logic       nxt_intr;
    int h, thr, crit, rec, rel, dgoal, stp, sum, nd;
    set      = 4'd0;
    nxt_intr = |(m_alert & ~intr_mask);
    h = int'(tel_health); thr = int'(cfg_thr_throttle); crit = int'(cfg_thr_critical);
    rec = int'(cfg_thr_recover); rel = int'(cfg_thr_release);
    dgoal = (cfg_dwell == 8'd0) ? 1 : int'(cfg_dwell);
    stp   = (cfg_ramp_step == 16'd0) ? 1 : int'(cfg_ramp_step);
    for (int c = 0; c < 4; c++) begin
      logic hit;
      hit = tel_vld && (int'(tel_ch) == c);
      if (hit && (m_st[c] == 1 || m_st[c] == 2 || m_st[c] == 4) && h < crit) begin
        m_st[c] = 3; m_rate[c] = 16'h0000; set[c] = 1'b1;
      end else if (hit && m_st[c] == 0) begin
        m_st[c] = 1;
      end else if (hit && (m_st[c] == 1 || m_st[c] == 4) && h < thr) begin
        m_st[c] = 2; m_rate[c] = cfg_throttle_rate; m_dw[c] = 8'd0;
      end else if (hit && m_st[c] == 3 && h > rel) begin
        m_st[c] = 2; m_rate[c] = cfg_throttle_rate; m_dw[c] = 8'd0;
      end else if (hit && m_st[c] == 2) begin
        if (h > rec) begin
          nd = (m_dw[c] == 8'hFF) ? 255 : int'(m_dw[c]) + 1;
          if (nd >= dgoal) begin m_st[c] = 4; m_dw[c] = 8'd0; end
          else m_dw[c] = 8'(nd);
        end else begin
          m_dw[c] = 8'd0;
        end
      end else if (m_st[c] == 4) begin
        sum = int'(m_rate[c]) + stp;
        if (sum >= 65535) begin m_rate[c] = 16'hFFFF; m_st[c] = 1; end
        else m_rate[c] = 16'(sum);
      end
    end
    m_alert = (m_alert & ~intr_clr) | set;
    m_intr  = nxt_intr;
  endtask

  // Advance one clock: record the expectation, then let the DUT take the edge.
  task automatic cycle();
    exp_t e;
    model_step();
    for (int c = 0; c < 4; c++) begin
      e.st[c*3 +: 3]    = 3'(m_st[c]);
      e.rate[c*16 +: 16] = m_rate[c];
    end
    e.alert = m_alert;
    e.intr  = m_intr;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] ch, input logic [3:0] h);
    tel_vld = v; tel_ch = ch; tel_health = h;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 4'd0);
    cfg_thr_throttle = 4'd8; cfg_thr_critical = 4'd2;
    cfg_thr_recover = 4'd12; cfg_thr_release = 4'd4;
    cfg_dwell = 8'd3; cfg_throttle_rate = 16'h4000; cfg_ramp_step = 16'h4000;
    intr_mask = 4'd0; intr_clr = 4'd0;
    #12;
    checks++; if (ch_state !== 12'd0) begin
      errors++; $display("FAIL reset_state got %h exp %h", ch_state, 12'd0); end
    checks++; if (rate_limit !== {64{1'b1}}) begin
      errors++; $display("FAIL reset_rate got %h exp all-ones", rate_limit); end
    checks++; if (alert_status !== 4'd0 || intr_alert !== 1'b0) begin
      errors++; $display("FAIL reset_alert got %b/%b exp 0/0", alert_status, intr_alert); end
    checks++; if (st3 !== 9'd0 || rate3 !== {48{1'b1}}) begin
      errors++; $display("FAIL reset_dut3 got %h/%h exp 0/all-ones", st3, rate3); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_nominal();
    exp_t e;
    drive(1'b1, 2'd0, 4'd10);
    cycle();
    drive(1'b0, 2'd0, 4'd0);
    e = sb.pop_front();
    checks++; if ({ch_state, rate_limit, alert_status, intr_alert} !==
                  {e.st, e.rate, e.alert, e.intr}) begin
      errors++; $display("FAIL nominal_sb got %h %h %b %b exp %h %h %b %b", ch_state,
                         rate_limit, alert_status, intr_alert, e.st, e.rate, e.alert, e.intr);
    end
    checks++; if (ch_state !== 12'h001 || rate_limit[15:0] !== 16'hFFFF) begin
      errors++; $display("FAIL nominal_ch0 got %h/%h exp 001/ffff", ch_state, rate_limit[15:0]);
    end
  endtask

  task automatic test_throttle();
    exp_t e;
    int hs[2] = '{10, 5};
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 2'd1, 4'(hs[k]));
      cycle();
      e = sb.pop_front();
      checks++; if ({ch_state, rate_limit, alert_status, intr_alert} !==
                    {e.st, e.rate, e.alert, e.intr}) begin
        errors++; $display("FAIL throttle_sb[%0d] got %h %h exp %h %h", k, ch_state,
                           rate_limit, e.st, e.rate);
      end
    end
    drive(1'b0, 2'd0, 4'd0);
    checks++; if (ch_state[5:3] !== 3'd2 || rate_limit[31:16] !== 16'h4000) begin
      errors++; $display("FAIL throttle_ch1 got %0d/%h exp 2/4000", ch_state[5:3],
                         rate_limit[31:16]);
    end
    checks++; if (rate_limit[15:0] !== 16'hFFFF || rate_limit[63:32] !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL throttle_others got %h exp ffff...", rate_limit);
    end
  endtask

  task automatic test_dwell_recover();
    exp_t e;
    int hs[6] = '{13, 13, 9, 13, 13, 13};
    logic [15:0] ramp[3] = '{16'h8000, 16'hC000, 16'hFFFF};
    logic [2:0]  rst_st[3] = '{3'd4, 3'd4, 3'd1};
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 2'd1, 4'(hs[k]));
      cycle();
      e = sb.pop_front();
      checks++; if ({ch_state, rate_limit, alert_status, intr_alert} !==
                    {e.st, e.rate, e.alert, e.intr}) begin
        errors++; $display("FAIL dwell_sb[%0d] got %h %h exp %h %h", k, ch_state,
                           rate_limit, e.st, e.rate);
      end
      checks++; if (ch_state[5:3] !== ((k == 5) ? 3'd4 : 3'd2)) begin
        errors++; $display("FAIL dwell_state[%0d] got %0d exp %0d", k, ch_state[5:3],
                           (k == 5) ? 4 : 2);
      end
    end
    drive(1'b0, 2'd0, 4'd0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      e = sb.pop_front();
      checks++; if ({ch_state, rate_limit} !== {e.st, e.rate}) begin
        errors++; $display("FAIL ramp_sb[%0d] got %h %h exp %h %h", k, ch_state, rate_limit,
                           e.st, e.rate);
      end
      checks++; if (rate_limit[31:16] !== ramp[k] || ch_state[5:3] !== rst_st[k]) begin
        errors++; $display("FAIL ramp[%0d] got %h/%0d exp %h/%0d", k, rate_limit[31:16],
                           ch_state[5:3], ramp[k], rst_st[k]);
      end
    end
  endtask

  task automatic test_alert_intr();
    exp_t e;
    // Each row: valid, health, clear, mask
    int sv[8] = '{1, 1, 0, 0, 0, 1, 1, 0};
    int sh[8] = '{10, 1, 0, 0, 0, 5, 1, 0};
    int sc[8] = '{0, 0, 0, 0, 0, 0, 4, 4};
    int sm[8] = '{0, 0, 0, 4, 4, 4, 4, 4};
    for (int k = 0; k < 8; k++) begin
      drive(1'(sv[k]), 2'd2, 4'(sh[k]));
      intr_clr  = 4'(sc[k]);
      intr_mask = 4'(sm[k]);
      cycle();
      e = sb.pop_front();
      checks++; if ({ch_state, rate_limit, alert_status, intr_alert} !==
                    {e.st, e.rate, e.alert, e.intr}) begin
        errors++; $display("FAIL alert_sb[%0d] got %h %h %b %b exp %h %h %b %b", k, ch_state,
                           rate_limit, alert_status, intr_alert, e.st, e.rate, e.alert, e.intr);
      end
      if (k == 1) begin
        checks++; if (ch_state[8:6] !== 3'd3 || rate_limit[47:32] !== 16'h0 ||
                      alert_status[2] !== 1'b1 || intr_alert !== 1'b0) begin
          errors++; $display("FAIL alert_entry got %0d/%h/%b/%b exp 3/0000/1/0",
                             ch_state[8:6], rate_limit[47:32], alert_status[2], intr_alert);
        end
      end
      if (k == 2) begin
        checks++; if (intr_alert !== 1'b1) begin
          errors++; $display("FAIL intr_two_cycles got %b exp 1", intr_alert); end
      end
      if (k == 4) begin
        checks++; if (intr_alert !== 1'b0) begin
          errors++; $display("FAIL intr_masked got %b exp 0", intr_alert); end
      end
      if (k == 6) begin
        checks++; if (alert_status[2] !== 1'b1 || ch_state[8:6] !== 3'd3) begin
          errors++; $display("FAIL set_beats_clr got %b/%0d exp 1/3", alert_status[2],
                             ch_state[8:6]);
        end
      end
      if (k == 7) begin
        checks++; if (alert_status[2] !== 1'b0) begin
          errors++; $display("FAIL w1c got %b exp 0", alert_status[2]); end
      end
    end
    drive(1'b0, 2'd0, 4'd0);
    intr_clr  = 4'd0;
    intr_mask = 4'd0;
  endtask

  task automatic test_recover_interrupt();
    exp_t e;
    int sv[7] = '{1, 1, 1, 1, 1, 0, 1};
    int sh[7] = '{10, 5, 13, 13, 13, 0, 6};
    for (int k = 0; k < 7; k++) begin
      drive(1'(sv[k]), 2'd3, 4'(sh[k]));
      cycle();
      e = sb.pop_front();
      checks++; if ({ch_state, rate_limit, alert_status, intr_alert} !==
                    {e.st, e.rate, e.alert, e.intr}) begin
        errors++; $display("FAIL rec_sb[%0d] got %h %h exp %h %h", k, ch_state, rate_limit,
                           e.st, e.rate);
      end
      checks++; if ({st3, rate3, al3, intr3} !==
                    {e.st[8:0], e.rate[47:0], e.alert[2:0], e.intr}) begin
        errors++; $display("FAIL dut3_ignore[%0d] got %h %h %b exp %h %h %b", k, st3, rate3,
                           al3, e.st[8:0], e.rate[47:0], e.alert[2:0]);
      end
      if (k == 5) begin
        checks++; if (ch_state[11:9] !== 3'd4 || rate_limit[63:48] !== 16'h8000) begin
          errors++; $display("FAIL rec_mid got %0d/%h exp 4/8000", ch_state[11:9],
                             rate_limit[63:48]);
        end
      end
    end
    drive(1'b0, 2'd0, 4'd0);
    checks++; if (ch_state[11:9] !== 3'd2 || rate_limit[63:48] !== 16'h4000) begin
      errors++; $display("FAIL rec_to_throttle got %0d/%h exp 2/4000", ch_state[11:9],
                         rate_limit[63:48]);
    end
  endtask

  task automatic test_boundaries();
    exp_t e;
    // ch0: health==throttle stays NOMINAL; health==critical throttles; health==recover
    // clears dwell; zero dwell and zero step act as 1.
    int sh[4] = '{8, 2, 12, 13};
    for (int k = 0; k < 8; k++) begin
      if (k < 4) drive(1'b1, 2'd0, 4'(sh[k]));
      else drive(1'b0, 2'd0, 4'd0);
      cfg_dwell     = (k >= 2) ? 8'd0 : 8'd3;
      cfg_ramp_step = (k == 4) ? 16'd0 : 16'h4000;
      cycle();
      e = sb.pop_front();
      checks++; if ({ch_state, rate_limit, alert_status, intr_alert} !==
                    {e.st, e.rate, e.alert, e.intr}) begin
        errors++; $display("FAIL bound_sb[%0d] got %h %h exp %h %h", k, ch_state, rate_limit,
                           e.st, e.rate);
      end
      if (k == 0 || k == 1 || k == 3 || k == 4) begin
        checks++; if (ch_state[2:0] !== ((k == 0) ? 3'd1 : (k == 1) ? 3'd2 : 3'd4)) begin
          errors++; $display("FAIL bound_state[%0d] got %0d", k, ch_state[2:0]); end
      end
      if (k == 4) begin
        checks++; if (rate_limit[15:0] !== 16'h4001) begin
          errors++; $display("FAIL zero_step got %h exp 4001", rate_limit[15:0]); end
      end
    end
    cfg_dwell = 8'd3;
    cfg_ramp_step = 16'h4000;
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    int sc[6] = '{1, 1, 1, 1, 0, 0};
    int sh[6] = '{5, 13, 13, 13, 1, 0};
    int sv[6] = '{1, 1, 1, 1, 1, 0};
    for (int k = 0; k < 6; k++) begin
      drive(1'(sv[k]), 2'(sc[k]), 4'(sh[k]));
      cycle();
      e = sb.pop_front();
      checks++; if ({ch_state, rate_limit, alert_status, intr_alert} !==
                    {e.st, e.rate, e.alert, e.intr}) begin
        errors++; $display("FAIL mid_sb[%0d] got %h %h %b %b exp %h %h %b %b", k, ch_state,
                           rate_limit, alert_status, intr_alert, e.st, e.rate, e.alert, e.intr);
      end
    end
    drive(1'b0, 2'd0, 4'd0);
    checks++; if (ch_state[2:0] !== 3'd3 || ch_state[5:3] !== 3'd4 || intr_alert !== 1'b1) begin
      errors++; $display("FAIL pre_reset got %h/%b exp ch0=3 ch1=4 intr=1", ch_state,
                         intr_alert);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ch_state !== 12'd0 || rate_limit !== {64{1'b1}}) begin
      errors++; $display("FAIL async_reset got %h %h exp 0 all-ones", ch_state, rate_limit);
    end
    checks++; if (alert_status !== 4'd0 || intr_alert !== 1'b0) begin
      errors++; $display("FAIL async_reset_alert got %b/%b exp 0/0", alert_status, intr_alert);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_throttle();
    test_dwell_recover();
    test_alert_intr();
    test_recover_interrupt();
    test_boundaries();
    test_reset_midflight();
    checks++; if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_left got %0d exp 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
